shifter_pipe: RTL and testbench
===============================

// Module: shifter_pipe
// PURPOSE
//  Parametrised, pipelined barrel shifter with carry-out for the execute stage.
//  Generalises the single-cycle 32-bit shifter: WIDTH/STAGES configurable, valid/ready handshake, flush, sideband tag.
//  Serves immediate-shift (DP/LDR-STR) and register-shift (RSR) forms. Feeds ALU operand B and the shifter C flag.
// PARAMETERS
//  WIDTH   32  data width; power of 2, >= 8
//  AMT_W   8   register-shift amount width (Rs[7:0]); must be > log2(WIDTH)
//  STAGES  2   pipeline register stages, 1..log2(WIDTH); log2(WIDTH) shift levels split evenly, remainder in stage 0
//  TAG_W   6   sideband tag width (dest reg/ROB id), passed through unchanged
// PORTS
//  clk        in   1       clock
//  reset      in   1       synchronous, active-high reset
//  flush      in   1       kill all in-flight ops
//  in_valid   in   1       input op valid
//  in_ready   out  1       block can accept input this cycle
//  in_data    in   WIDTH   operand to shift (Rm)
//  in_amt     in   AMT_W   shift amount; imm mode uses low log2(WIDTH) bits only
//  in_op      in   2       00 LSL, 01 LSR, 10 ASR, 11 ROR/RRX
//  in_regmode in   1       1 = register-shift semantics, 0 = immediate semantics
//  in_carry   in   1       current C flag
//  in_tag     in   TAG_W   sideband
//  out_valid  out  1       result valid
//  out_ready  in   1       downstream accepts
//  out_data   out  WIDTH   shifted result
//  out_carry  out  1       shifter carry-out
//  out_tag    out  TAG_W   tag of the result
// BEHAVIOUR
//  Reset: all stage valids 0; out_valid=0, out_data=0, out_carry=0, out_tag=0; in_ready=1 the cycle after reset drops.
//  Latency: exactly STAGES cycles from accept (in_valid&in_ready) to out_valid with no backpressure; throughput 1/cycle.
//  Handshake: stage k loads when empty or stage k+1 (or output if last) moves this cycle; in_ready = ~flush & (stage0 empty | stage0 moves).
//   Output holds data/carry/tag stable while out_valid & ~out_ready. No bubble insertion, no op drop/dup.
//  Flush: clears every stage valid at the edge; in_ready=0 that cycle, input not taken. flush+reset: reset wins (same result).
//  Immediate semantics (n = amt mod WIDTH):
//   LSL n=0 -> data, C=in_carry; n>0 -> data<<n, C=data[WIDTH-n]
//   LSR n=0 -> 0, C=data[WIDTH-1] (LSR #WIDTH); n>0 -> data>>n, C=data[n-1]
//   ASR n=0 -> all copies of msb, C=msb; n>0 -> arith shift, C=data[n-1]
//   ROR n=0 -> RRX: {in_carry,data[WIDTH-1:1]}, C=data[0]; n>0 -> rotate right n, C=data[n-1]
//  Register semantics (a = full AMT_W amount):
//   a=0 any op -> data unchanged, C=in_carry
//   LSL 0<a<WIDTH as imm; a=WIDTH -> 0, C=data[0]; a>WIDTH -> 0, C=0
//   LSR 0<a<WIDTH as imm; a=WIDTH -> 0, C=data[WIDTH-1]; a>WIDTH -> 0, C=0
//   ASR 0<a<WIDTH as imm; a>=WIDTH -> sign fill, C=msb
//   ROR a mod WIDTH=0 -> data, C=data[WIDTH-1]; else rotate by a mod WIDTH, C=bit (a mod WIDTH)-1
//  Decode in stage 0: special cases resolved to force_zero/force_sign/pass/rrx flags + preselected carry; shift levels
//   otherwise track carry as last bit shifted out (ASR/ROR rotate/fill accordingly). No X on out_* when out_valid=0 (hold).
// STRUCTURE
//  Package shifter_pkg: shift_op_e enum (SH_LSL,SH_LSR,SH_ASR,SH_ROR), stage payload struct (data, carry, op, residual
//   amount, special flags, tag), localparam LVLS=$clog2(WIDTH).
//  Sub-module shifter_level: combinational one-level shift by 2^k with carry update, instantiated LVLS times via generate;
//   shifter_pipe owns decode, stage registers and handshake.
// TESTING
//  imm LSL, data=32'h8000_0001, amt=1, C=0 -> out 32'h0000_0002, C=1, after exactly STAGES cycles
//  imm ROR amt=0 (RRX), data=32'h0000_0003, C=1 -> out 32'h8000_0001, C=1
//  reg LSR a=32 / a=33, data=32'h8000_0000 -> out 0,C=1 / out 0,C=0; reg ASR a=200, data=32'h8000_0000 -> 32'hFFFF_FFFF,C=1
//  reg ROR a=64, data=32'h1234_5678 -> unchanged, C=0; reg any op a=0, C=1 -> unchanged, C=1
//  back-to-back 8 ops with random out_ready stalls -> all 8 results in order, tags match, held stable during stall
//  flush with pipe full plus in_valid=1 -> no out_valid next cycle, input not accepted; WIDTH=64/STAGES=3 rerun of above

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared types and stage-split helpers for the pipelined barrel shifter.
package shifter_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_op_e;

  // Cases resolved entirely at decode; the shift levels then see a zero amount.
  typedef struct packed {
    logic force_zero;
    logic force_sign;
    logic pass;
    logic rrx;
  } special_t;

  // First shift level handled by pipeline stage s; any remainder levels go to stage 0.
  function automatic int unsigned lvl_lo(int unsigned lvls, int unsigned stages, int unsigned s);
    if (s == 0) return 0;
    return (lvls % stages) + s * (lvls / stages);
  endfunction

  function automatic int unsigned lvl_cnt(int unsigned lvls, int unsigned stages, int unsigned s);
    return (lvls / stages) + ((s == 0) ? (lvls % stages) : 0);
  endfunction

endpackage

// File: rtl/shifter_level.sv
// One combinational shift level: shifts by a fixed power of two when enabled and tracks carry
// as the last bit shifted (or rotated) out.
module shifter_level
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHIFT = 1
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic             carry_in,
  input  logic [1:0]       op,
  input  logic             en,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out
);

  always_comb begin
    data_out  = data_in;
    carry_out = carry_in;
    if (en) begin
      unique case (shift_op_e'(op))
        SH_LSL: begin
          data_out  = data_in << SHIFT;
          carry_out = data_in[WIDTH-SHIFT];
        end
        SH_LSR: begin
          data_out  = data_in >> SHIFT;
          carry_out = data_in[SHIFT-1];
        end
        SH_ASR: begin
          data_out  = $signed(data_in) >>> SHIFT;
          carry_out = data_in[SHIFT-1];
        end
        SH_ROR: begin
          data_out  = {data_in[SHIFT-1:0], data_in[WIDTH-1:SHIFT]};
          carry_out = data_in[SHIFT-1];
        end
      endcase
    end
  end

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter with carry-out: decode in stage 0, log2(WIDTH) shift levels spread
// over STAGES registered stages, valid/ready handshake with flush and a pass-through tag.
module shifter_pipe
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned AMT_W  = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_op,
  input  logic             in_regmode,
  input  logic             in_carry,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned LVLS = $clog2(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             carry;
    shift_op_e        op;
    logic [LVLS-1:0]  amt;
    logic [TAG_W-1:0] tag;
  } stage_t;

  // Decode
  logic [LVLS-1:0] imm_n;
  logic            msb, a_zero, a_eq_w, a_gt_w, pre_carry;
  special_t        spec;
  stage_t          dec;

  assign imm_n  = in_amt[LVLS-1:0];
  assign msb    = in_data[WIDTH-1];
  assign a_zero = (in_amt == '0);
  assign a_eq_w = (in_amt == AMT_W'(WIDTH));
  assign a_gt_w = (in_amt > AMT_W'(WIDTH));

  always_comb begin
    spec      = '0;
    pre_carry = in_carry;
    if (!in_regmode) begin
      if (imm_n == '0) begin
        unique case (shift_op_e'(in_op))
          SH_LSL: spec.pass = 1'b1;
          SH_LSR: begin spec.force_zero = 1'b1; pre_carry = msb;        end
          SH_ASR: begin spec.force_sign = 1'b1; pre_carry = msb;        end
          SH_ROR: begin spec.rrx        = 1'b1; pre_carry = in_data[0]; end
        endcase
      end
    end else if (a_zero) begin
      spec.pass = 1'b1;
    end else begin
      unique case (shift_op_e'(in_op))
        SH_LSL: begin
          if (a_eq_w) begin spec.force_zero = 1'b1; pre_carry = in_data[0]; end
          else if (a_gt_w) begin spec.force_zero = 1'b1; pre_carry = 1'b0; end
        end
        SH_LSR: begin
          if (a_eq_w) begin spec.force_zero = 1'b1; pre_carry = msb; end
          else if (a_gt_w) begin spec.force_zero = 1'b1; pre_carry = 1'b0; end
        end
        SH_ASR: begin
          if (a_eq_w || a_gt_w) begin spec.force_sign = 1'b1; pre_carry = msb; end
        end
        SH_ROR: begin
          if (imm_n == '0) begin spec.pass = 1'b1; pre_carry = msb; end
        end
      endcase
    end
  end

  // Special cases carry their final value with a zero residual amount so every level passes.
  always_comb begin
    dec.data  = in_data;
    dec.carry = in_carry;
    dec.op    = shift_op_e'(in_op);
    dec.amt   = imm_n;
    dec.tag   = in_tag;
    if (|spec) begin
      dec.amt   = '0;
      dec.carry = pre_carry;
      if (spec.force_zero)      dec.data = '0;
      else if (spec.force_sign) dec.data = {WIDTH{msb}};
      else if (spec.rrx)        dec.data = {in_carry, in_data[WIDTH-1:1]};
    end
  end

  // Pipeline stages
  for (genvar s = 0; s < STAGES; s++) begin : gen_stage
    localparam int unsigned Lo  = lvl_lo(LVLS, STAGES, s);
    localparam int unsigned Cnt = lvl_cnt(LVLS, STAGES, s);

    stage_t src, stage_d, stage_q;
    logic   src_valid, valid_q, load_s;

    if (s == 0) begin : g_src
      assign src       = dec;
      assign src_valid = in_valid & in_ready;
    end else begin : g_src
      assign src       = gen_stage[s-1].stage_q;
      assign src_valid = gen_stage[s-1].valid_q;
    end

    // A stage loads when empty or when its contents move on this cycle.
    if (s == STAGES - 1) begin : g_load
      assign load_s = ~valid_q | out_ready;
    end else begin : g_load
      assign load_s = ~valid_q | gen_stage[s+1].load_s;
    end

    for (genvar j = 0; j < Cnt; j++) begin : gen_lvl
      stage_t           lin, lout;
      logic [WIDTH-1:0] sh_data;
      logic             sh_carry;

      if (j == 0) begin : g_in
        assign lin = src;
      end else begin : g_in
        assign lin = gen_lvl[j-1].lout;
      end

      shifter_level #(
        .WIDTH (WIDTH),
        .SHIFT (1 << (Lo + j))
      ) u_level (
        .data_in   (lin.data),
        .carry_in  (lin.carry),
        .op        (lin.op),
        .en        (lin.amt[Lo+j]),
        .data_out  (sh_data),
        .carry_out (sh_carry)
      );

      always_comb begin
        lout       = lin;
        lout.data  = sh_data;
        lout.carry = sh_carry;
      end
    end

    assign stage_d = gen_lvl[Cnt-1].lout;

    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= 1'b0;
        stage_q <= '0;
      end else begin
        if (flush)       valid_q <= 1'b0;
        else if (load_s) valid_q <= src_valid;
        if (load_s && src_valid && !flush) stage_q <= stage_d;
      end
    end
  end

  assign in_ready  = ~flush & gen_stage[0].load_s;
  assign out_valid = gen_stage[STAGES-1].valid_q;
  assign out_data  = gen_stage[STAGES-1].stage_q.data;
  assign out_carry = gen_stage[STAGES-1].stage_q.carry;
  assign out_tag   = gen_stage[STAGES-1].stage_q.tag;

  logic unused_payload;
  assign unused_payload = ^{gen_stage[STAGES-1].stage_q.op, gen_stage[STAGES-1].stage_q.amt};

endmodule

// File: tb/tb_shifter_pipe.sv
// Bench for shifter_pipe: a 32-bit/2-stage and a 64-bit/3-stage instance exercised in turn
// with directed cases, random streams under backpressure, and flush.
module tb_shifter_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1, flush = 1'b0, out_ready = 1'b1, in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic [7:0]  in_amt = '0;
  logic [1:0]  in_op = '0;
  logic        in_regmode = 1'b0, in_carry = 1'b0, sel = 1'b0;
  logic [5:0]  in_tag = '0;

  logic        a_in_ready, a_out_valid, a_out_carry;
  logic [31:0] a_out_data;
  logic [5:0]  a_out_tag;
  logic        b_in_ready, b_out_valid, b_out_carry;
  logic [63:0] b_out_data;
  logic [5:0]  b_out_tag;

  logic        cur_in_ready, cur_out_valid, cur_out_carry;
  logic [63:0] cur_out_data;
  logic [5:0]  cur_out_tag;

  always #5 clk = ~clk;

  shifter_pipe u_dut32 (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid & ~sel),
    .in_ready   (a_in_ready),
    .in_data    (in_data[31:0]),
    .in_amt     (in_amt),
    .in_op      (in_op),
    .in_regmode (in_regmode),
    .in_carry   (in_carry),
    .in_tag     (in_tag),
    .out_valid  (a_out_valid),
    .out_ready  (out_ready),
    .out_data   (a_out_data),
    .out_carry  (a_out_carry),
    .out_tag    (a_out_tag)
  );

  shifter_pipe #(
    .WIDTH  (64),
    .STAGES (3)
  ) u_dut64 (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid & sel),
    .in_ready   (b_in_ready),
    .in_data    (in_data),
    .in_amt     (in_amt),
    .in_op      (in_op),
    .in_regmode (in_regmode),
    .in_carry   (in_carry),
    .in_tag     (in_tag),
    .out_valid  (b_out_valid),
    .out_ready  (out_ready),
    .out_data   (b_out_data),
    .out_carry  (b_out_carry),
    .out_tag    (b_out_tag)
  );

  assign cur_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign cur_out_valid = sel ? b_out_valid : a_out_valid;
  assign cur_out_carry = sel ? b_out_carry : a_out_carry;
  assign cur_out_data  = sel ? b_out_data  : {32'h0, a_out_data};
  assign cur_out_tag   = sel ? b_out_tag   : a_out_tag;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  amt;
    logic [1:0]  op;
    logic        rm;
    logic        c;
    logic [5:0]  tag;
    logic [63:0] ed;
    logic        ec;
  } op_t;

  op_t        pend_q[$];
  op_t        exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  logic [5:0] tag_ctr = '0;

  function automatic int width();
    return sel ? 64 : 32;
  endfunction

  function automatic int stages();
    return sel ? 3 : 2;
  endfunction

  function automatic logic [63:0] ones(input int w);
    return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  // Reference: result and carry straight from the shift rules, one output bit at a time.
  function automatic logic [64:0] model(input int w, input logic [63:0] d, input int amt,
                                        input int op, input bit rm, input bit c);
    logic [63:0] m, r;
    logic        msb;
    int          n;
    m   = ones(w);
    msb = d[w-1];
    r   = '0;
    if (rm && amt == 0) return {c, d};
    if (!rm || op == 3) n = amt % w;
    else n = amt;
    if (!rm && n == 0) begin
      case (op)
        0:       return {c, d};
        1:       return {msb, 64'h0};
        2:       return {msb, msb ? m : 64'h0};
        default: return {d[0], (64'(c) << (w - 1)) | (d >> 1)};
      endcase
    end
    if (rm && op == 3 && n == 0) return {msb, d};
    if (rm && op != 3 && amt >= w) begin
      if (op == 2) return {msb, msb ? m : 64'h0};
      if (amt > w) return {1'b0, 64'h0};
      return {(op == 0) ? d[0] : msb, 64'h0};
    end
    for (int i = 0; i < w; i++) begin
      case (op)
        0:       r[i] = (i >= n) ? d[i-n] : 1'b0;
        1:       r[i] = (i + n < w) ? d[i+n] : 1'b0;
        2:       r[i] = (i + n < w) ? d[i+n] : msb;
        default: r[i] = d[(i+n)%w];
      endcase
    end
    return {(op == 0) ? d[w-n] : d[n-1], r};
  endfunction

  function automatic op_t rand_op(input int w, input logic [5:0] tag);
    op_t t;
    int  sp[5];
    sp    = '{0, w - 1, w, w + 1, 2 * w};
    t.d   = {$urandom, $urandom} & ones(w);
    t.amt = ($urandom_range(0, 2) == 0) ? 8'(sp[$urandom_range(0, 4)]) : 8'($urandom_range(0, 255));
    t.op  = 2'($urandom_range(0, 3));
    t.rm  = 1'($urandom_range(0, 1));
    t.c   = 1'($urandom_range(0, 1));
    t.tag = tag;
    {t.ec, t.ed} = model(w, t.d, int'(t.amt), int'(t.op), t.rm, t.c);
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, required %0h", name, obs, exp);
    end
  endtask

  task automatic drive(input op_t t);
    in_data    = t.d;
    in_amt     = t.amt;
    in_op      = t.op;
    in_regmode = t.rm;
    in_carry   = t.c;
    in_tag     = t.tag;
  endtask

  // Offers queued ops, checks results in order, holds during stalls, and optionally latency.
  task automatic run(input bit stalls, input bit chk_lat, input string name);
    int          cyc = 0, acc_cyc = 0;
    bit          held = 0;
    logic [63:0] hd = '0;
    logic        hc = 1'b0;
    logic [5:0]  ht = '0;
    op_t         e;
    while ((pend_q.size() != 0 || exp_q.size() != 0) && cyc < 400) begin
      @(negedge clk);
      in_valid = (pend_q.size() != 0);
      if (in_valid) drive(pend_q[0]);
      out_ready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
      #4;
      if (held) begin
        chk({name, " hold valid"}, 64'(cur_out_valid), 64'd1);
        chk({name, " hold data"}, cur_out_data, hd);
        chk({name, " hold carry"}, 64'(cur_out_carry), 64'(hc));
        chk({name, " hold tag"}, 64'(cur_out_tag), 64'(ht));
      end
      if (cur_out_valid && out_ready) begin
        n_checks++;
        assert (exp_q.size() != 0)
        else begin
          n_fail++;
          $error("FAIL %s extra output: observed tag %0d, required none", name, cur_out_tag);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk({name, " data"}, cur_out_data, e.ed);
          chk({name, " carry"}, 64'(cur_out_carry), 64'(e.ec));
          chk({name, " tag"}, 64'(cur_out_tag), 64'(e.tag));
          if (chk_lat) chk({name, " latency"}, 64'(cyc - acc_cyc), 64'(stages()));
        end
      end
      held = cur_out_valid && !out_ready;
      hd   = cur_out_data;
      hc   = cur_out_carry;
      ht   = cur_out_tag;
      if (in_valid && cur_in_ready) begin
        exp_q.push_back(pend_q.pop_front());
        acc_cyc = cyc;
      end
      cyc++;
    end
    n_checks++;
    assert (cyc < 400)
    else begin
      n_fail++;
      $error("FAIL %s timeout: observed %0d pending, required 0", name,
             pend_q.size() + exp_q.size());
    end
    pend_q.delete();
    exp_q.delete();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic dir(input string name, input logic [63:0] d, input int amt, input logic [1:0] op,
                     input bit rm, input bit c, input logic [63:0] ed, input bit ec);
    op_t t;
    t.d = d; t.amt = 8'(amt); t.op = op; t.rm = rm; t.c = c;
    t.tag = tag_ctr; t.ed = ed; t.ec = ec;
    tag_ctr++;
    pend_q.push_back(t);
    run(1'b0, 1'b1, name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #4;
    chk("reset out_valid", 64'(cur_out_valid), 64'd0);
    chk("reset out_data", cur_out_data, 64'd0);
    chk("reset out_carry", 64'(cur_out_carry), 64'd0);
    chk("reset out_tag", 64'(cur_out_tag), 64'd0);
    chk("reset in_ready", 64'(cur_in_ready), 64'd1);
  endtask

  task automatic flush_test();
    out_ready = 1'b0;
    for (int k = 0; k < stages(); k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      drive(rand_op(width(), tag_ctr));
      tag_ctr++;
      #4;
      chk("fill in_ready", 64'(cur_in_ready), 64'd1);
    end
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    drive(rand_op(width(), tag_ctr));
    #4;
    chk("full out_valid", 64'(cur_out_valid), 64'd1);
    chk("flush in_ready", 64'(cur_in_ready), 64'd0);
    @(negedge clk);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k <= stages(); k++) begin
      #4;
      chk("post-flush out_valid", 64'(cur_out_valid), 64'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [63:0] msb, m;
    int          w;
    for (int p = 0; p < 2; p++) begin
      sel = p[0];
      w   = width();
      msb = 64'd1 << (w - 1);
      m   = ones(w);
      do_reset();
      dir("imm_lsl1", msb | 64'd1, 1, 2'd0, 1'b0, 1'b0, 64'd2, 1'b1);
      dir("imm_rrx", 64'd3, 0, 2'd3, 1'b0, 1'b1, msb | 64'd1, 1'b1);
      dir("reg_lsr_w", msb, w, 2'd1, 1'b1, 1'b0, 64'd0, 1'b1);
      dir("reg_lsr_w1", msb, w + 1, 2'd1, 1'b1, 1'b1, 64'd0, 1'b0);
      dir("reg_asr_200", msb, 200, 2'd2, 1'b1, 1'b0, m, 1'b1);
      dir("reg_ror_2w", 64'h1234_5678, 2 * w, 2'd3, 1'b1, 1'b1, 64'h1234_5678, 1'b0);
      dir("reg_lsl_w", 64'd1, w, 2'd0, 1'b1, 1'b0, 64'd0, 1'b1);
      dir("imm_lsr0", msb, 0, 2'd1, 1'b0, 1'b0, 64'd0, 1'b1);
      dir("imm_asr0", msb | 64'd2, 0, 2'd2, 1'b0, 1'b0, m, 1'b1);
      for (int op = 0; op < 4; op++)
        dir("reg_amt0", 64'hA5C3_0F0F, 0, 2'(op), 1'b1, 1'b1, 64'hA5C3_0F0F, 1'b1);
      for (int k = 0; k < 8; k++) begin
        pend_q.push_back(rand_op(w, tag_ctr));
        tag_ctr++;
      end
      run(1'b1, 1'b0, "stream8");
      for (int k = 0; k < 60; k++) begin
        pend_q.push_back(rand_op(w, tag_ctr));
        tag_ctr++;
      end
      run(1'b1, 1'b0, "random");
      flush_test();
      dir("after_flush", msb | 64'd1, 1, 2'd0, 1'b0, 1'b0, 64'd2, 1'b1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
